// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
// Radix-2 shift-add multiply and restoring divide on magnitudes, one step per cycle, sign fix in a final cycle.
module md_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_is_div;
  logic                 r_sx;
  logic                 r_neg;
  logic                 r_dz;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_is_md;
  logic                 w_signed;
  logic                 w_div;
  logic                 w_req;
  logic                 w_accept;
  logic                 w_mt_hi;
  logic                 w_mt_lo;
  logic                 w_last;
  logic                 w_fix_commit;
  logic [WIDTH-1:0]     w_abs_x;
  logic [WIDTH-1:0]     w_abs_y;
  logic [WIDTH:0]       w_mul_add;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]       w_sh;
  logic [WIDTH+1:0]     w_sub;
  logic                 w_div_neg;
  logic [2*WIDTH-1:0]   w_div_acc;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // Request decode; flush always beats a request presented in IDLE.
  assign w_is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_req    = (r_state == S_IDLE) && start && !flush;
  assign w_accept = w_req && w_is_md;
  assign w_mt_hi  = w_req && (op == OP_MTHI);
  assign w_mt_lo  = w_req && (op == OP_MTLO);
  assign w_abs_x  = (w_signed && x[WIDTH-1]) ? -x : x;
  assign w_abs_y  = (w_signed && y[WIDTH-1]) ? -y : y;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Multiply: {carry, upper half} gets the multiplicand when the multiplier LSB is set, then shift right.
  assign w_mul_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_mul_acc = {w_mul_add, r_acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend bits out and quotient bits in.
  assign w_sh      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_sub     = {1'b0, w_sh} - {2'b00, r_mcand};
  assign w_div_neg = w_sub[WIDTH+1];
  assign w_div_acc = {(w_div_neg ? w_sh[WIDTH-1:0] : w_sub[WIDTH-1:0]), r_acc[WIDTH-2:0], ~w_div_neg};

  // With a zero divisor the remainder is |x|, so restoring the sign of x hands back the original x.
  assign w_prod_fix = r_neg ? -r_acc : r_acc;
  assign w_quot     = r_acc[WIDTH-1:0];
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
  assign w_quot_fix = r_dz ? {WIDTH{1'b1}} : (r_neg ? -w_quot : w_quot);
  assign w_rem_fix  = r_sx ? -w_rem : w_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CALC;
      end
      S_CALC: begin
        if (flush)       w_next = S_IDLE;
        else if (w_last) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    w_fix_commit = 1'b0;
    case (r_state)
      S_CALC: busy = 1'b1;
      S_FIX: begin
        busy         = 1'b1;
        w_fix_commit = !flush;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_is_div <= 1'b0;
      r_sx     <= 1'b0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= w_fix_commit;
      if (w_accept) begin
        r_cnt    <= '0;
        r_is_div <= w_div;
        r_sx     <= w_signed && x[WIDTH-1];
        r_neg    <= w_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
        r_dz     <= (y == '0);
        r_mcand  <= w_div ? w_abs_y : w_abs_x;
        r_acc    <= {{WIDTH{1'b0}}, (w_div ? w_abs_x : w_abs_y)};
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= r_is_div ? w_div_acc : w_mul_acc;
      end
      if (w_mt_hi) r_hi <= x;
      if (w_mt_lo) r_lo <= x;
      if (w_fix_commit) begin
        if (r_is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quot_fix;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit
// Drives a WIDTH=32 and a WIDTH=8 instance and checks them against an arithmetic reference model.
module tb_md_unit;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef struct packed {
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] x32 = '0, y32 = '0, hi32, lo32;
  logic        busy32, done32;
  logic [7:0]  x8 = '0, y8 = '0, hi8, lo8;
  logic        busy8, done8;
  logic [31:0] snap_hi, snap_lo;
  logic        snap_busy, snap_done;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op), .x(x32), .y(y32), .flush(flush),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  md_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op), .x(x8), .y(y8), .flush(flush),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  function automatic void model(input int w, input logic [3:0] o, input logic [31:0] a, input logic [31:0] bv,
                                input logic [31:0] hin, input logic [31:0] lin,
                                output logic [31:0] ho, output logic [31:0] lo_o);
    logic [63:0] mask, ua, ub, pp;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, bv} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    ho = hin;
    lo_o = lin;
    case (o)
      OP_MULT:  begin pp = 64'(sa * sb); ho = 32'((pp >> w) & mask); lo_o = 32'(pp & mask); end
      OP_MULTU: begin pp = ua * ub;      ho = 32'((pp >> w) & mask); lo_o = 32'(pp & mask); end
      OP_DIV: begin
        if (ub == 64'd0) begin lo_o = 32'(mask); ho = 32'(ua); end
        else begin
          pp = 64'(sa / sb); lo_o = 32'(pp & mask);
          pp = 64'(sa % sb); ho = 32'(pp & mask);
        end
      end
      OP_DIVU: begin
        if (ub == 64'd0) begin lo_o = 32'(mask); ho = 32'(ua); end
        else begin lo_o = 32'(ua / ub); ho = 32'(ua % ub); end
      end
      OP_MTHI: ho = 32'(ua);
      OP_MTLO: lo_o = 32'(ua);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m, v;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 6))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'd1 << (w - 1);
      3:       v = 32'($urandom_range(1, 9));
      4:       v = -32'($urandom_range(1, 9));
      default: v = $urandom;
    endcase
    return v & m;
  endfunction

  task automatic mt(input int w, input logic [3:0] o, input logic [31:0] a);
    @(negedge clk);
    op = o;
    if (w == 8) begin start8 = 1'b1; x8 = a[7:0]; end
    else begin start32 = 1'b1; x32 = a; end
    @(negedge clk);
    start8 = 1'b0;
    start32 = 1'b0;
  endtask

  // Issues one request and samples busy/done for a fixed window; optionally injects
  // a second start (1), a flush (2) or a reset (3) right after sample inj_k.
  task automatic run_op(input int w, input logic [3:0] o, input logic [31:0] a, input logic [31:0] bv,
                        input int inj_k, input int inj_kind,
                        output int busy_cnt, output int done_at, output int done_cnt, output int overlap);
    logic ob, od;
    busy_cnt = 0; done_at = 0; done_cnt = 0; overlap = 0;
    @(negedge clk);
    op = o;
    if (w == 8) begin start8 = 1'b1; x8 = a[7:0]; y8 = bv[7:0]; end
    else begin start32 = 1'b1; x32 = a; y32 = bv; end
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    op = 4'($urandom); x32 = $urandom; y32 = $urandom; x8 = 8'($urandom); y8 = 8'($urandom);
    for (int k = 1; k <= w + 12; k++) begin
      ob = (w == 8) ? busy8 : busy32;
      od = (w == 8) ? done8 : done32;
      if (ob) busy_cnt++;
      if (od) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        if (ob) overlap++;
      end
      if (k == inj_k) begin
        case (inj_kind)
          1: begin op = OP_DIVU; if (w == 8) start8 = 1'b1; else start32 = 1'b1; end
          2: flush = 1'b1;
          3: begin
            rst = 1'b1;
            #1;
            snap_hi   = (w == 8) ? 32'(hi8) : hi32;
            snap_lo   = (w == 8) ? 32'(lo8) : lo32;
            snap_busy = (w == 8) ? busy8 : busy32;
            snap_done = (w == 8) ? done8 : done32;
          end
          default: ;
        endcase
      end else if (k == inj_k + 1) begin
        start8 = 1'b0; start32 = 1'b0; flush = 1'b0; rst = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({hi32, lo32} !== 64'd0) begin errors++; $display("FAIL reset hilo32: got %h required 0", {hi32, lo32}); end
    checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL reset flags32: got %b required 00", {busy32, done32}); end
    checks++; if ({hi8, lo8} !== 16'd0) begin errors++; $display("FAIL reset hilo8: got %h required 0", {hi8, lo8}); end
    checks++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL reset flags8: got %b required 00", {busy8, done8}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t v[7];
    int bc, da, dc, ov;
    v[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    v[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[2] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    v[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    v[5] = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    v[6] = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      run_op(32, v[i].o, v[i].a, v[i].b, 0, 0, bc, da, dc, ov);
      checks++; if (hi32 !== v[i].eh) begin errors++; $display("FAIL directed[%0d] hi: got %h required %h", i, hi32, v[i].eh); end
      checks++; if (lo32 !== v[i].el) begin errors++; $display("FAIL directed[%0d] lo: got %h required %h", i, lo32, v[i].el); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL directed[%0d] busy cycles: got %0d required 33", i, bc); end
      checks++; if (da !== 34) begin errors++; $display("FAIL directed[%0d] done cycle: got %0d required 34", i, da); end
      checks++; if (dc !== 1 || ov !== 0) begin errors++; $display("FAIL directed[%0d] done pulse: got %0d pulses %0d overlaps required 1/0", i, dc, ov); end
    end
  endtask

  task automatic test_random();
    int bc, da, dc, ov;
    logic [3:0]  o;
    logic [31:0] a, b, eh, el;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(1, 4));
      a = pick(32);
      b = pick(32);
      model(32, o, a, b, hi32, lo32, eh, el);
      run_op(32, o, a, b, 0, 0, bc, da, dc, ov);
      checks++; if ({hi32, lo32} !== {eh, el}) begin errors++; $display("FAIL random op=%0d x=%h y=%h: got %h_%h required %h_%h", o, a, b, hi32, lo32, eh, el); end
      checks++; if (da !== 34 || dc !== 1) begin errors++; $display("FAIL random timing op=%0d: got done at %0d (%0d pulses) required 34 (1)", o, da, dc); end
    end
  endtask

  task automatic test_mt();
    @(negedge clk);
    op = OP_MTHI; x32 = 32'hAAAA_5555; start32 = 1'b1;
    @(negedge clk);
    checks++; if (hi32 !== 32'hAAAA_5555) begin errors++; $display("FAIL mthi: got %h required aaaa5555", hi32); end
    checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL mthi flags: got %b required 00", {busy32, done32}); end
    op = OP_MTLO; x32 = 32'h0F0F_0F0F;
    @(negedge clk);
    start32 = 1'b0;
    checks++; if ({hi32, lo32} !== {32'hAAAA_5555, 32'h0F0F_0F0F}) begin errors++; $display("FAIL mtlo: got %h_%h required aaaa5555_0f0f0f0f", hi32, lo32); end
    checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL mtlo flags: got %b required 00", {busy32, done32}); end
    @(negedge clk);
    checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL mt after: got %b required 00", {busy32, done32}); end
  endtask

  task automatic test_undefined_op();
    logic [3:0]  bad[4];
    logic [31:0] h, l;
    bad[0] = 4'd0; bad[1] = 4'd7; bad[2] = 4'd9; bad[3] = 4'd15;
    h = $urandom; l = $urandom;
    mt(32, OP_MTHI, h);
    mt(32, OP_MTLO, l);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op = bad[i]; x32 = $urandom; y32 = $urandom; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      @(negedge clk);
      checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL undefined op %0d flags: got %b required 00", bad[i], {busy32, done32}); end
      checks++; if ({hi32, lo32} !== {h, l}) begin errors++; $display("FAIL undefined op %0d hilo: got %h_%h required %h_%h", bad[i], hi32, lo32, h, l); end
    end
  endtask

  task automatic test_back_to_back();
    int bc, da, dc, ov;
    logic [31:0] a, b, eh, el;
    a = $urandom; b = $urandom;
    model(32, OP_MULT, a, b, hi32, lo32, eh, el);
    run_op(32, OP_MULT, a, b, 5, 1, bc, da, dc, ov);
    checks++; if ({hi32, lo32} !== {eh, el}) begin errors++; $display("FAIL start while busy result: got %h_%h required %h_%h", hi32, lo32, eh, el); end
    checks++; if (bc !== 33 || da !== 34) begin errors++; $display("FAIL start while busy timing: got busy %0d done %0d required 33/34", bc, da); end
    checks++; if (dc !== 1 || ov !== 0) begin errors++; $display("FAIL start while busy pulses: got %0d/%0d required 1/0", dc, ov); end
  endtask

  task automatic test_flush();
    int bc, da, dc, ov;
    logic [31:0] h, l;
    mt(32, OP_MTHI, 32'd0);
    mt(32, OP_MTLO, 32'd0);
    run_op(32, OP_DIV, $urandom, 32'($urandom_range(1, 999)), 10, 2, bc, da, dc, ov);
    checks++; if (bc !== 10) begin errors++; $display("FAIL flush calc busy cycles: got %0d required 10", bc); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL flush calc done: got %0d pulses required 0", dc); end
    checks++; if ({hi32, lo32} !== 64'd0) begin errors++; $display("FAIL flush calc hilo: got %h_%h required 0_0", hi32, lo32); end
    h = $urandom; l = $urandom;
    mt(32, OP_MTHI, h);
    mt(32, OP_MTLO, l);
    run_op(32, OP_MULT, $urandom | 32'd1, $urandom | 32'd1, 33, 2, bc, da, dc, ov);
    checks++; if (bc !== 33 || dc !== 0) begin errors++; $display("FAIL flush fix: got busy %0d done %0d required 33/0", bc, dc); end
    checks++; if ({hi32, lo32} !== {h, l}) begin errors++; $display("FAIL flush fix hilo: got %h_%h required %h_%h", hi32, lo32, h, l); end
    @(negedge clk);
    flush = 1'b1; start32 = 1'b1; op = OP_MTHI; x32 = ~h;
    @(negedge clk);
    op = OP_MULT;
    @(negedge clk);
    flush = 1'b0; start32 = 1'b0;
    @(negedge clk);
    checks++; if (hi32 !== h) begin errors++; $display("FAIL flush+start mthi: got %h required %h", hi32, h); end
    checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL flush+start mult: got %b required 00", {busy32, done32}); end
  endtask

  task automatic test_reset_mid();
    int bc, da, dc, ov;
    mt(32, OP_MTHI, 32'h1234_5678);
    mt(32, OP_MTLO, 32'h9ABC_DEF0);
    run_op(32, OP_DIV, $urandom, 32'd3, 20, 3, bc, da, dc, ov);
    checks++; if ({snap_hi, snap_lo} !== 64'd0) begin errors++; $display("FAIL reset mid hilo: got %h_%h required 0_0", snap_hi, snap_lo); end
    checks++; if ({snap_busy, snap_done} !== 2'b00) begin errors++; $display("FAIL reset mid flags: got %b required 00", {snap_busy, snap_done}); end
    checks++; if (bc !== 20 || dc !== 0) begin errors++; $display("FAIL reset mid activity: got busy %0d done %0d required 20/0", bc, dc); end
  endtask

  task automatic test_width8();
    int bc, da, dc, ov;
    logic [3:0]  o;
    logic [31:0] a, b, eh, el;
    run_op(8, OP_MULT, 32'h7F, 32'h7F, 0, 0, bc, da, dc, ov);
    checks++; if ({hi8, lo8} !== 16'h3F01) begin errors++; $display("FAIL w8 mult 7f: got %h_%h required 3f_01", hi8, lo8); end
    checks++; if (bc !== 9 || da !== 10 || dc !== 1 || ov !== 0) begin errors++; $display("FAIL w8 timing: got busy %0d done %0d pulses %0d overlap %0d required 9/10/1/0", bc, da, dc, ov); end
    mt(8, OP_MTHI, 32'h00);
    mt(8, OP_MTLO, 32'h00);
    run_op(8, OP_DIV, 32'h85, 32'h03, 4, 2, bc, da, dc, ov);
    checks++; if (bc !== 4 || dc !== 0 || {hi8, lo8} !== 16'h0000) begin errors++; $display("FAIL w8 flush: got busy %0d done %0d hilo %h_%h required 4/0/00_00", bc, dc, hi8, lo8); end
    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(1, 4));
      a = pick(8);
      b = pick(8);
      model(8, o, a, b, 32'(hi8), 32'(lo8), eh, el);
      run_op(8, o, a, b, 0, 0, bc, da, dc, ov);
      checks++; if ({24'd0, hi8, 24'd0, lo8} !== {eh, el}) begin errors++; $display("FAIL w8 random op=%0d x=%h y=%h: got %h_%h required %h_%h", o, a[7:0], b[7:0], hi8, lo8, eh[7:0], el[7:0]); end
      checks++; if (da !== 10 || dc !== 1) begin errors++; $display("FAIL w8 random timing: got done %0d pulses %0d required 10/1", da, dc); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mt();
    test_undefined_op();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
